mac_pipe_ctrl: RTL and testbench

Sequencing controller for the floating-point MAC pipeline. It accepts operand pairs under a valid/ready handshake and tracks a per-stage valid bit through the fixed-depth datapath (sign, exponent-add and significand-multiply status stages). It drives per-stage register enables, accumulator clear/update, and a held result-valid handshake. One accumulation run covers `len` operand pairs from `start` to `done`.

---
 rtl/mac_ctrl_pkg.sv | 7 +
 rtl/mac_pipe_ctrl_if.sv | 35 +++
 rtl/mac_valid_pipe.sv | 22 ++
 rtl/mac_pipe_ctrl.sv | 85 ++++++++
 tb/tb_mac_pipe_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding and default sizes for the MAC pipeline controller
package mac_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_e;
  localparam int DEF_STAGES = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int BUBBLE_W   = 16;
endpackage

// File: rtl/mac_pipe_ctrl_if.sv
// mac_pipe_ctrl_if: control/handshake bundle of the MAC controller; MAC_CTRL_PERF_EN adds bubble_cnt
interface mac_pipe_ctrl_if import mac_ctrl_pkg::*; #(
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [STAGES-1:0] stage_en;
  logic              acc_clear;
  logic              acc_en;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef MAC_CTRL_PERF_EN
  logic [BUBBLE_W-1:0] bubble_cnt;
`endif
  modport slave (
    input  start, len, abort, in_valid, out_ready,
`ifdef MAC_CTRL_PERF_EN
    output bubble_cnt,
`endif
    output in_ready, stage_en, acc_clear, acc_en, out_valid, busy, done
  );
  modport master (
    output start, len, abort, in_valid, out_ready,
`ifdef MAC_CTRL_PERF_EN
    input  bubble_cnt,
`endif
    input  in_ready, stage_en, acc_clear, acc_en, out_valid, busy, done
  );
endinterface

// File: rtl/mac_valid_pipe.sv
// mac_valid_pipe: per-stage valid shift register driving stage enables and accumulator update
module mac_valid_pipe #(
  parameter int STAGES = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              accept_i,
  output logic [STAGES-1:0] vld_o,
  output logic [STAGES-1:0] stage_en_o,
  output logic              acc_en_o
);
  logic [STAGES-1:0] vld_q, vld_d;
  assign stage_en_o = {vld_q[STAGES-2:0], accept_i};
  assign vld_d      = flush_i ? '0 : stage_en_o;
  assign vld_o      = vld_q;
  assign acc_en_o   = vld_q[STAGES-1];
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) vld_q <= '0;
    else         vld_q <= vld_d;
  end
endmodule

// File: rtl/mac_pipe_ctrl.sv
// mac_pipe_ctrl: run sequencer for the FP MAC pipeline; MAC_CTRL_PERF_EN adds a saturating bubble counter
module mac_pipe_ctrl import mac_ctrl_pkg::*; #(
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic            clock,
  input logic            resetn,
  mac_pipe_ctrl_if.slave bus
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic              first_q, first_d, done_q, done_d;
  logic              accept, go;
  logic [STAGES-1:0] vld;
  assign go            = state_q == IDLE && bus.start && bus.len != '0 && !bus.abort;
  assign bus.in_ready  = state_q == RUN && left_q != '0;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.acc_clear = state_q == RUN && first_q;
  assign bus.out_valid = state_q == HOLD;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  mac_valid_pipe #(.STAGES(STAGES)) u_vld (
    .clock      (clock),
    .resetn     (resetn),
    .flush_i    (bus.abort),
    .accept_i   (accept),
    .vld_o      (vld),
    .stage_en_o (bus.stage_en),
    .acc_en_o   (bus.acc_en)
  );
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    first_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = RUN;
        left_d  = bus.len;
        first_d = 1'b1;
      end
      RUN: if (accept) begin
        left_d  = left_q - 1'b1;
        state_d = left_q == CNT_W'(1) ? DRAIN : RUN;
      end
      // leave once the pipe empties on the next edge, so HOLD follows the last acc_en
      DRAIN: state_d = ~|(vld << 1) ? HOLD : DRAIN;
      HOLD: if (bus.out_ready) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      left_d  = '0;
      first_d = 1'b0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      left_q  <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end
`ifdef MAC_CTRL_PERF_EN
  logic [BUBBLE_W-1:0] bubble_q, bubble_d;
  assign bubble_d = go ? '0
                  : (state_q == RUN && bus.in_ready && !bus.in_valid && !bus.abort && ~&bubble_q)
                    ? bubble_q + 1'b1 : bubble_q;
  assign bus.bubble_cnt = bubble_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) bubble_q <= '0;
    else         bubble_q <= bubble_d;
  end
`endif
endmodule

// File: tb/tb_mac_pipe_ctrl.sv
// tb_mac_pipe_ctrl: directed-vector bench for mac_pipe_ctrl with STAGES=4, CNT_W=8
module tb_mac_pipe_ctrl;
  import mac_ctrl_pkg::*;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [9:0] obs, e;
  mac_pipe_ctrl_if #(.STAGES(4), .CNT_W(8)) bus ();
  mac_pipe_ctrl #(.STAGES(4), .CNT_W(8)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  assign obs = {bus.busy, bus.in_ready, bus.stage_en, bus.acc_clear, bus.acc_en, bus.out_valid, bus.done};

  // expected {busy,in_ready,stage_en,acc_clear,acc_en,out_valid,done} for run cycle c:
  // acc = accept-cycle mask, l = last accept, ov_to = last out_valid cycle
  function automatic logic [9:0] exp_obs(int c, logic [63:0] acc, int l, int ov_to);
    logic [3:0] se;
    logic ae;
    for (int i = 0; i < 4; i++) se[i] = (c - i >= 0) ? acc[c - i] : 1'b0;
    ae = (c >= 4) ? acc[c - 4] : 1'b0;
    return {c >= 1 && c <= ov_to, c >= 1 && c <= l, se, c == 1, ae,
            c >= l + 5 && c <= ov_to, c == ov_to + 1};
  endfunction

  task automatic cyc;
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs;
    bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    resetn = 1'b0;
    cyc(); cyc();
    vectors++;
    if (obs !== 10'b0) begin miscompares++; $display("FAIL reset_state got %b want %b", obs, 10'b0); end
    resetn = 1'b1;
    cyc();
    bus.start = 1'b1; bus.len = 8'd5; bus.in_valid = 1'b1;
    cyc(); bus.start = 1'b0;
    cyc(); cyc();
    #1;
    e = exp_obs(3, 64'b1110, 5, 100);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL mid_run got %b want %b", obs, e); end
    resetn = 1'b0;
    #1;
    vectors++;
    if (obs !== 10'b0) begin miscompares++; $display("FAIL reset_async got %b want %b", obs, 10'b0); end
    bus.in_valid = 1'b0;
    #3 resetn = 1'b1;
    cyc();
    vectors++;
    if (obs !== 10'b0) begin miscompares++; $display("FAIL idle_after_reset got %b want %b", obs, 10'b0); end
    bus.start = 1'b1; bus.len = 8'd1;
    cyc(); bus.start = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.in_ready, bus.acc_clear} !== 3'b111) begin
      miscompares++; $display("FAIL restart got %b want 111", {bus.busy, bus.in_ready, bus.acc_clear});
    end
    bus.abort = 1'b1;
    cyc(); bus.abort = 1'b0;
    vectors++;
    if (obs !== 10'b0) begin miscompares++; $display("FAIL abort_run got %b want %b", obs, 10'b0); end
  endtask

  task automatic test_basic;
    idle_inputs(); cyc();
    bus.start = 1'b1; bus.len = 8'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      e = exp_obs(c, 64'b1110, 3, 8);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL basic c=%0d got %b want %b", c, obs, e); end
      cyc();
    end
  endtask

  task automatic test_toggle;
    logic [63:0] m;
    m = 64'hAA;
    idle_inputs(); cyc();
    bus.start = 1'b1; bus.len = 8'd4; bus.out_ready = 1'b1;
    cyc(); bus.start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      bus.in_valid = m[c];
      #1;
      e = exp_obs(c, m, 7, 12);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL toggle c=%0d got %b want %b", c, obs, e); end
      cyc();
    end
`ifdef MAC_CTRL_PERF_EN
    vectors++;
    if (bus.bubble_cnt !== 16'd3) begin miscompares++; $display("FAIL bubble_cnt got %0d want 3", bus.bubble_cnt); end
`endif
  endtask

  task automatic test_hold;
    idle_inputs(); cyc();
    bus.start = 1'b1; bus.len = 8'd1; bus.in_valid = 1'b1;
    cyc(); bus.start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      bus.out_ready = c >= 15;
      bus.start = c >= 7 && c <= 14;
      bus.len = 8'd2;
      #1;
      e = exp_obs(c, 64'b10, 1, 15);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL hold c=%0d got %b want %b", c, obs, e); end
      cyc();
    end
  endtask

  task automatic test_abort_drain;
    idle_inputs(); cyc();
    bus.start = 1'b1; bus.len = 8'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.abort = c == 4;
      #1;
      e = exp_obs(c, 64'b110, 2, 100);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL abort_pre c=%0d got %b want %b", c, obs, e); end
      cyc();
    end
    bus.abort = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      #1;
      vectors++;
      if (obs !== 10'b0) begin miscompares++; $display("FAIL abort_post c=%0d got %b want %b", c, obs, 10'b0); end
      cyc();
    end
  endtask

  task automatic test_len_edges;
    int cnt;
    cnt = 0;
    idle_inputs(); cyc();
    bus.start = 1'b1; bus.len = 8'd0; bus.in_valid = 1'b1;
    cyc(); bus.start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      vectors++;
      if (obs !== 10'b0) begin miscompares++; $display("FAIL len0 c=%0d got %b want %b", c, obs, 10'b0); end
      cyc();
    end
    bus.start = 1'b1; bus.len = 8'd255; bus.out_ready = 1'b1;
    cyc(); bus.start = 1'b0;
    for (int c = 1; c <= 262; c++) begin
      #1;
      if (bus.in_ready && bus.in_valid) cnt++;
      if (c == 256) begin
        vectors++;
        if ({bus.busy, bus.in_ready} !== 2'b10) begin
          miscompares++; $display("FAIL len255_ready got %b want 10", {bus.busy, bus.in_ready});
        end
      end
      if (c == 260) begin
        vectors++;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL len255_ov got %b want 1", bus.out_valid); end
      end
      if (c == 261) begin
        vectors++;
        if ({bus.busy, bus.done} !== 2'b01) begin
          miscompares++; $display("FAIL len255_done got %b want 01", {bus.busy, bus.done});
        end
      end
      cyc();
    end
    vectors++;
    if (cnt !== 255) begin miscompares++; $display("FAIL len255_accepts got %0d want 255", cnt); end
`ifdef MAC_CTRL_PERF_EN
    vectors++;
    if (bus.bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL bubble_clear got %0d want 0", bus.bubble_cnt); end
`endif
  endtask

  task automatic test_back_to_back;
    idle_inputs(); cyc();
    bus.start = 1'b1; bus.len = 8'd1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      e = exp_obs(c, 64'b10, 1, 6);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL b2b c=%0d got %b want %b", c, obs, e); end
      if (c == 7) begin bus.start = 1'b1; bus.len = 8'd2; end
      cyc();
    end
    bus.start = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.in_ready, bus.acc_clear} !== 3'b111) begin
      miscompares++; $display("FAIL b2b_restart got %b want 111", {bus.busy, bus.in_ready, bus.acc_clear});
    end
    bus.abort = 1'b1;
    cyc(); bus.abort = 1'b0;
    vectors++;
    if (obs !== 10'b0) begin miscompares++; $display("FAIL b2b_abort got %b want %b", obs, 10'b0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_hold();
    test_abort_drain();
    test_len_edges();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
